// File: rtl/imem_line_responder_pkg.sv
// ----------------------------------------------------------------------------
// imem_pkg
// Shared types and constants for the instruction-line responder.
//   imem_state_t : responder FSM states
//   line_t       : one full instruction line (LINE_BEATS * BEAT_W bits)
//   OFFSET_W     : byte-offset bits within a line (32-byte line)
//   WIDX_W       : word index bits within a line
//   TAG_W        : address bits above the line offset
// ----------------------------------------------------------------------------
package imem_pkg;

    localparam int IMEM_LINE_BEATS = 4;
    localparam int IMEM_BEAT_W     = 64;
    localparam int WORDS_PER_LINE  = (IMEM_LINE_BEATS * IMEM_BEAT_W) / 32;
    localparam int OFFSET_W        = 5;
    localparam int WIDX_W          = $clog2(WORDS_PER_LINE);
    localparam int TAG_W           = 32 - OFFSET_W;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL,
        RESP
    } imem_state_t;

    typedef logic [IMEM_LINE_BEATS*IMEM_BEAT_W-1:0] line_t;

endpackage

// File: rtl/imem_line_responder_if.sv
// ----------------------------------------------------------------------------
// imem_line_responder_if
// Bundles the fetch-side request/response signals and the backing-memory
// burst signals of the instruction-line responder.
//   slave  : the responder (consumes requests, issues bursts)
//   master : the environment (fetch stage + memory arbiter)
// ----------------------------------------------------------------------------
interface imem_line_responder_if #(
    parameter int BEAT_W = 64
);
    logic [31:0]       imem_addr;
    logic [3:0]        imem_rmask;
    logic              flush;
    logic [31:0]       imem_rdata;
    logic              imem_resp;
    logic [31:0]       bmem_addr;
    logic              bmem_read;
    logic              bmem_ready;
    logic [BEAT_W-1:0] bmem_rdata;
    logic              bmem_rvalid;

    modport slave (
        input  imem_addr, imem_rmask, flush, bmem_ready, bmem_rdata, bmem_rvalid,
        output imem_rdata, imem_resp, bmem_addr, bmem_read
    );

    modport master (
        output imem_addr, imem_rmask, flush, bmem_ready, bmem_rdata, bmem_rvalid,
        input  imem_rdata, imem_resp, bmem_addr, bmem_read
    );
endinterface

// File: rtl/imem_line_responder_line_buf.sv
// ----------------------------------------------------------------------------
// imem_line_buf
// Storage for the single instruction line plus its tag and valid bit.
//   beat_we/beat_idx/beat_data : write one burst beat into the line
//   tag_we/tag_in              : install tag and mark the line valid
//   inval                      : clear the valid bit (a fill is starting)
//   lookup_tag -> hit          : combinational tag compare
//   rd_idx -> rd_word          : combinational 32-bit word select
// ----------------------------------------------------------------------------
module imem_line_buf
    import imem_pkg::*;
#(
    parameter int LINE_BEATS = IMEM_LINE_BEATS,
    parameter int BEAT_W     = IMEM_BEAT_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          beat_we,
    input  logic [$clog2(LINE_BEATS)-1:0] beat_idx,
    input  logic [BEAT_W-1:0]             beat_data,
    input  logic                          tag_we,
    input  logic [TAG_W-1:0]              tag_in,
    input  logic                          inval,
    input  logic [TAG_W-1:0]              lookup_tag,
    input  logic [WIDX_W-1:0]             rd_idx,
    output logic                          hit,
    output logic [31:0]                   rd_word
);

    logic [LINE_BEATS*BEAT_W-1:0] line_q, line_d;
    logic [TAG_W-1:0]             tag_q, tag_d;
    logic                         valid_q, valid_d;

    always_comb begin
        line_d  = line_q;
        tag_d   = tag_q;
        valid_d = valid_q;
        if (beat_we) begin
            line_d[beat_idx*BEAT_W +: BEAT_W] = beat_data;
        end
        if (inval) begin
            valid_d = 1'b0;
        end
        if (tag_we) begin
            tag_d   = tag_in;
            valid_d = 1'b1;
        end
    end

    // Line contents are qualified by valid_q, so they need no reset.
    always_ff @(posedge clk) begin
        line_q <= line_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            tag_q   <= tag_d;
            valid_q <= valid_d;
        end
    end

    assign hit     = valid_q && (tag_q == lookup_tag);
    assign rd_word = line_q[rd_idx*32 +: 32];

endmodule

// File: rtl/imem_line_responder.sv
// ----------------------------------------------------------------------------
// imem_line_responder
// Responder end of the fetch->imem link. Holds one 32-byte instruction line:
// hits answer one cycle after the request, misses burst-fill the line from
// backing memory and then answer. A flush while a miss is outstanding lets
// the fill complete but suppresses its response.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : imem_addr/imem_rmask/flush in, imem_rdata/imem_resp out,
//                bmem_addr/bmem_read out, bmem_ready/bmem_rdata/bmem_rvalid in
// ----------------------------------------------------------------------------
module imem_line_responder
    import imem_pkg::*;
#(
    parameter int LINE_BEATS = IMEM_LINE_BEATS,
    parameter int BEAT_W     = IMEM_BEAT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    imem_line_responder_if.slave  bus
);

    localparam int                BCNT_W    = $clog2(LINE_BEATS);
    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(LINE_BEATS - 1);

    imem_state_t       state_q, state_d;
    logic [BCNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic              kill_q, kill_d;
    logic [31:2]       req_addr_q, req_addr_d;
    logic              imem_resp_q, imem_resp_d;
    logic [31:0]       imem_rdata_q, imem_rdata_d;
    logic              bmem_read_q, bmem_read_d;
    logic [31:0]       bmem_addr_q, bmem_addr_d;

    logic              buf_hit;
    logic [31:0]       buf_word;
    logic [WIDX_W-1:0] rd_idx;
    logic              beat_we;
    logic              tag_we;
    logic              inval;

    // The single read port serves hit lookups in IDLE and the miss response
    // in RESP; the two never overlap.
    assign rd_idx = (state_q == RESP) ? req_addr_q[OFFSET_W-1:2]
                                      : bus.imem_addr[OFFSET_W-1:2];

    imem_line_buf #(
        .LINE_BEATS (LINE_BEATS),
        .BEAT_W     (BEAT_W)
    ) u_line_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .beat_we    (beat_we),
        .beat_idx   (beat_cnt_q),
        .beat_data  (bus.bmem_rdata),
        .tag_we     (tag_we),
        .tag_in     (req_addr_q[31:OFFSET_W]),
        .inval      (inval),
        .lookup_tag (bus.imem_addr[31:OFFSET_W]),
        .rd_idx     (rd_idx),
        .hit        (buf_hit),
        .rd_word    (buf_word)
    );

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        kill_d       = kill_q;
        req_addr_d   = req_addr_q;
        imem_resp_d  = 1'b0;
        imem_rdata_d = imem_rdata_q;
        bmem_read_d  = bmem_read_q;
        bmem_addr_d  = bmem_addr_q;
        beat_we      = 1'b0;
        tag_we       = 1'b0;
        inval        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.imem_rmask != 4'd0) begin
                    if (buf_hit) begin
                        imem_resp_d  = 1'b1;
                        imem_rdata_d = buf_word;
                    end else begin
                        req_addr_d  = bus.imem_addr[31:2];
                        bmem_addr_d = {bus.imem_addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
                        bmem_read_d = 1'b1;
                        inval       = 1'b1;
                        state_d     = REQ;
                    end
                end
            end
            REQ: begin
                if (bus.flush) kill_d = 1'b1;
                if (bus.bmem_ready) begin
                    bmem_read_d = 1'b0;
                    beat_cnt_d  = '0;
                    state_d     = FILL;
                end
            end
            FILL: begin
                if (bus.flush) kill_d = 1'b1;
                if (bus.bmem_rvalid) begin
                    beat_we = 1'b1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        tag_we  = 1'b1;
                        state_d = RESP;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            RESP: begin
                // A flush landing in this very cycle also suppresses the answer.
                if (!kill_q && !bus.flush) begin
                    imem_resp_d  = 1'b1;
                    imem_rdata_d = buf_word;
                end
                kill_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            kill_q       <= 1'b0;
            req_addr_q   <= '0;
            imem_resp_q  <= 1'b0;
            imem_rdata_q <= '0;
            bmem_read_q  <= 1'b0;
            bmem_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            kill_q       <= kill_d;
            req_addr_q   <= req_addr_d;
            imem_resp_q  <= imem_resp_d;
            imem_rdata_q <= imem_rdata_d;
            bmem_read_q  <= bmem_read_d;
            bmem_addr_q  <= bmem_addr_d;
        end
    end

    assign bus.imem_resp  = imem_resp_q;
    assign bus.imem_rdata = imem_rdata_q;
    assign bus.bmem_read  = bmem_read_q;
    assign bus.bmem_addr  = bmem_addr_q;

endmodule

// File: tb/tb_imem_line_responder.sv
// ----------------------------------------------------------------------------
// tb_imem_line_responder
// Drives the responder with directed and randomized fetch requests while a
// backing-memory model answers bursts. Expected words come from a sparse
// word-addressed memory and a one-line cache model (valid + tag).
// ----------------------------------------------------------------------------
module tb_imem_line_responder;
    import imem_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    imem_line_responder_if #(.BEAT_W(64)) bus ();

    imem_line_responder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int bread_cycles = 0;

    typedef struct {
        int          c;
        logic [31:0] d;
    } resp_t;
    resp_t resp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.imem_resp === 1'b1) resp_q.push_back('{cyc, bus.imem_rdata});
        if (bus.bmem_read === 1'b1) bread_cycles <= bread_cycles + 1;
    end

    // Backing memory: random word per address, created on first touch.
    int unsigned mem [int unsigned];
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        int unsigned k;
        k = a >> 2;
        if (!mem.exists(k)) mem[k] = $urandom;
        return mem[k];
    endfunction
    function automatic logic [63:0] beat_data(input logic [31:0] line_a, input int b);
        return {mem_word(line_a + 32'(8*b + 4)), mem_word(line_a + 32'(8*b))};
    endfunction

    // Cache model: one line, valid + tag.
    bit          mdl_valid = 1'b0;
    logic [26:0] mdl_tag   = '0;
    function automatic bit mdl_hit(input logic [31:0] a);
        return mdl_valid && (mdl_tag == a[31:5]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, output int icyc);
        bus.imem_addr  = a;
        bus.imem_rmask = 4'($urandom_range(1, 15));
        icyc = cyc;
        tick();
        bus.imem_rmask = 4'd0;
    endtask

    task automatic wait_resp(input int max);
        int n;
        n = 0;
        while (resp_q.size() == 0 && n < max) begin
            tick();
            n++;
        end
    endtask

    // Answers one burst: waits for bmem_read, accepts after rdly cycles, then
    // streams 4 beats with rvalid following pat[0..plen-1] (1 afterwards).
    // flush_after >= 0 pulses flush in the cycle after that beat index.
    task automatic serve_burst(input int rdly, input bit [15:0] pat, input int plen,
                               input int flush_after, input logic [31:0] line_a,
                               output logic [31:0] seen, output bit ok, output int last_cyc);
        int n, beat, g;
        bit v, fl;
        n = 0; ok = 1'b1; seen = '0; last_cyc = 0;
        while (bus.bmem_read !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (bus.bmem_read !== 1'b1) begin
            ok = 1'b0;
            return;
        end
        seen = bus.bmem_addr;
        repeat (rdly) tick();
        bus.bmem_ready = 1'b1;
        tick();
        bus.bmem_ready = 1'b0;
        beat = 0; g = 0; fl = 1'b0;
        while (beat < 4) begin
            v = (g < plen) ? pat[g] : 1'b1;
            g++;
            bus.flush       = fl;
            fl              = 1'b0;
            bus.bmem_rvalid = v;
            bus.bmem_rdata  = v ? beat_data(line_a, beat) : {$urandom, $urandom};
            if (v) begin
                last_cyc = cyc;
                if (beat == flush_after) fl = 1'b1;
                beat++;
            end
            tick();
        end
        bus.bmem_rvalid = 1'b0;
        bus.flush       = fl;
        tick();
        bus.flush = 1'b0;
    endtask

    task automatic test_reset();
        bus.imem_addr = '0; bus.imem_rmask = '0; bus.flush = 1'b0;
        bus.bmem_ready = 1'b0; bus.bmem_rdata = '0; bus.bmem_rvalid = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        n_cmp++; if (bus.imem_resp !== 1'b0) begin n_bad++; $display("FAIL reset_resp got %b want 0", bus.imem_resp); end
        n_cmp++; if (bus.imem_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got %h want 0", bus.imem_rdata); end
        n_cmp++; if (bus.bmem_read !== 1'b0) begin n_bad++; $display("FAIL reset_bmem_read got %b want 0", bus.bmem_read); end
        n_cmp++; if (bus.bmem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_bmem_addr got %h want 0", bus.bmem_addr); end
        rst_n = 1'b1;
        mdl_valid = 1'b0;
        tick();
    endtask

    task automatic test_cold_miss();
        int ic, lc;
        bit ok;
        logic [31:0] seen;
        resp_q.delete();
        issue(32'h6000_0008, ic);
        serve_burst(2, 16'h0, 0, -1, 32'h6000_0000, seen, ok, lc);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL cold_burst_timeout got no bmem_read want bmem_read"); end
        n_cmp++; if (seen !== 32'h6000_0000) begin n_bad++; $display("FAIL cold_bmem_addr got %h want 60000000", seen); end
        wait_resp(8); tick(); tick();
        n_cmp++;
        if (resp_q.size() != 1) begin
            n_bad++; $display("FAIL cold_resp_count got %0d want 1", resp_q.size());
        end else begin
            n_cmp++; if (resp_q[0].c != lc + 2) begin n_bad++; $display("FAIL cold_latency got cycle %0d want %0d", resp_q[0].c, lc + 2); end
            n_cmp++; if (resp_q[0].d !== mem_word(32'h6000_0008)) begin n_bad++; $display("FAIL cold_rdata got %h want %h", resp_q[0].d, mem_word(32'h6000_0008)); end
        end
        mdl_valid = 1'b1; mdl_tag = 27'(32'h6000_0000 >> 5);
    endtask

    task automatic test_hit_stream(input logic [31:0] base, input string nm);
        int ic0, br0;
        logic [31:0] a;
        resp_q.delete();
        br0 = bread_cycles;
        ic0 = cyc;
        for (int i = 0; i < 8; i++) begin
            bus.imem_addr  = base + 32'(4*i) + 32'($urandom_range(0, 3));
            bus.imem_rmask = 4'($urandom_range(1, 15));
            tick();
        end
        bus.imem_rmask = 4'd0;
        tick(); tick();
        n_cmp++; if (bread_cycles != br0) begin n_bad++; $display("FAIL %s_no_bmem got %0d read cycles want 0", nm, bread_cycles - br0); end
        n_cmp++;
        if (resp_q.size() != 8) begin
            n_bad++; $display("FAIL %s_count got %0d want 8", nm, resp_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                a = base + 32'(4*i);
                n_cmp++; if (resp_q[i].c != ic0 + 1 + i) begin n_bad++; $display("FAIL %s_timing[%0d] got cycle %0d want %0d", nm, i, resp_q[i].c, ic0 + 1 + i); end
                n_cmp++; if (resp_q[i].d !== mem_word(a)) begin n_bad++; $display("FAIL %s_word[%0d] got %h want %h", nm, i, resp_q[i].d, mem_word(a)); end
            end
        end
    endtask

    task automatic test_new_line();
        int ic, lc;
        bit ok;
        logic [31:0] seen;
        resp_q.delete();
        issue(32'h6000_0020, ic);
        n_cmp++; if (bus.bmem_read !== 1'b1) begin n_bad++; $display("FAIL newline_miss got bmem_read=%b want 1", bus.bmem_read); end
        serve_burst(0, 16'h0, 0, -1, 32'h6000_0020, seen, ok, lc);
        n_cmp++; if (seen !== 32'h6000_0020) begin n_bad++; $display("FAIL newline_bmem_addr got %h want 60000020", seen); end
        wait_resp(8); tick();
        n_cmp++;
        if (resp_q.size() != 1) begin
            n_bad++; $display("FAIL newline_resp_count got %0d want 1", resp_q.size());
        end else begin
            n_cmp++; if (resp_q[0].d !== mem_word(32'h6000_0020)) begin n_bad++; $display("FAIL newline_rdata got %h want %h", resp_q[0].d, mem_word(32'h6000_0020)); end
        end
        mdl_valid = 1'b1; mdl_tag = 27'(32'h6000_0020 >> 5);
    endtask

    task automatic test_flush_fill();
        int ic, lc, br0;
        bit ok;
        logic [31:0] seen;
        resp_q.delete();
        issue(32'h6000_0040, ic);
        serve_burst(1, 16'h0, 0, 1, 32'h6000_0040, seen, ok, lc);
        repeat (4) tick();
        n_cmp++; if (resp_q.size() != 0) begin n_bad++; $display("FAIL flush_suppress got %0d resp want 0", resp_q.size()); end
        mdl_valid = 1'b1; mdl_tag = 27'(32'h6000_0040 >> 5);
        resp_q.delete();
        br0 = bread_cycles;
        issue(32'h6000_0044, ic);
        wait_resp(4); tick();
        n_cmp++; if (bread_cycles != br0) begin n_bad++; $display("FAIL flush_line_kept got %0d read cycles want 0", bread_cycles - br0); end
        n_cmp++;
        if (resp_q.size() != 1) begin
            n_bad++; $display("FAIL flush_hit_count got %0d want 1", resp_q.size());
        end else begin
            n_cmp++; if (resp_q[0].c != ic + 1) begin n_bad++; $display("FAIL flush_hit_latency got cycle %0d want %0d", resp_q[0].c, ic + 1); end
            n_cmp++; if (resp_q[0].d !== mem_word(32'h6000_0044)) begin n_bad++; $display("FAIL flush_hit_rdata got %h want %h", resp_q[0].d, mem_word(32'h6000_0044)); end
        end
    endtask

    task automatic test_gapped();
        int ic, lc;
        bit ok;
        logic [31:0] seen;
        resp_q.delete();
        issue(32'h6000_0094, ic);
        serve_burst(1, 16'h0059, 7, -1, 32'h6000_0080, seen, ok, lc);
        wait_resp(8); tick();
        n_cmp++;
        if (resp_q.size() != 1) begin
            n_bad++; $display("FAIL gapped_resp_count got %0d want 1", resp_q.size());
        end else begin
            n_cmp++; if (resp_q[0].c != lc + 2) begin n_bad++; $display("FAIL gapped_latency got cycle %0d want %0d", resp_q[0].c, lc + 2); end
            n_cmp++; if (resp_q[0].d !== mem_word(32'h6000_0094)) begin n_bad++; $display("FAIL gapped_rdata got %h want %h", resp_q[0].d, mem_word(32'h6000_0094)); end
        end
        mdl_valid = 1'b1; mdl_tag = 27'(32'h6000_0080 >> 5);
        test_hit_stream(32'h6000_0080, "gapped_line");
    endtask

    task automatic test_reset_mid_burst();
        int ic, n, lc;
        bit ok;
        logic [31:0] seen;
        resp_q.delete();
        issue(32'h6000_00C0, ic);
        n = 0;
        while (bus.bmem_read !== 1'b1 && n < 20) begin tick(); n++; end
        bus.bmem_ready = 1'b1; tick(); bus.bmem_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bus.bmem_rvalid = 1'b1; bus.bmem_rdata = beat_data(32'h6000_00C0, b); tick();
        end
        bus.bmem_rvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.imem_resp !== 1'b0) begin n_bad++; $display("FAIL midrst_resp got %b want 0", bus.imem_resp); end
        n_cmp++; if (bus.imem_rdata !== 32'h0) begin n_bad++; $display("FAIL midrst_rdata got %h want 0", bus.imem_rdata); end
        n_cmp++; if (bus.bmem_addr !== 32'h0) begin n_bad++; $display("FAIL midrst_bmem_addr got %h want 0", bus.bmem_addr); end
        tick();
        rst_n = 1'b1;
        mdl_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            bus.bmem_rvalid = 1'b1; bus.bmem_rdata = {$urandom, $urandom}; tick();
        end
        bus.bmem_rvalid = 1'b0;
        repeat (3) tick();
        n_cmp++; if (resp_q.size() != 0) begin n_bad++; $display("FAIL midrst_stray got %0d resp want 0", resp_q.size()); end
        n_cmp++; if (bus.bmem_read !== 1'b0) begin n_bad++; $display("FAIL midrst_idle got bmem_read=%b want 0", bus.bmem_read); end
        issue(32'h6000_0000, ic);
        n_cmp++; if (bus.bmem_read !== 1'b1) begin n_bad++; $display("FAIL midrst_remiss got bmem_read=%b want 1", bus.bmem_read); end
        serve_burst(0, 16'h0, 0, -1, 32'h6000_0000, seen, ok, lc);
        n_cmp++; if (seen !== 32'h6000_0000) begin n_bad++; $display("FAIL midrst_bmem_addr got %h want 60000000", seen); end
        wait_resp(8); tick();
        n_cmp++;
        if (resp_q.size() != 1) begin
            n_bad++; $display("FAIL midrst_resp_count got %0d want 1", resp_q.size());
        end else begin
            n_cmp++; if (resp_q[0].d !== mem_word(32'h6000_0000)) begin n_bad++; $display("FAIL midrst_rdata got %h want %h", resp_q[0].d, mem_word(32'h6000_0000)); end
        end
        mdl_valid = 1'b1; mdl_tag = 27'(32'h6000_0000 >> 5);
    endtask

    task automatic test_random();
        int ic, lc, fa, want_n, want_c;
        bit ok, hit;
        logic [31:0] a, la, seen;
        for (int it = 0; it < 30; it++) begin
            la = 32'h6000_0000 + 32'($urandom_range(0, 3) << 5);
            a  = la + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
            hit = mdl_hit(a);
            resp_q.delete();
            issue(a, ic);
            if (hit) begin
                wait_resp(4); tick();
                want_n = 1; want_c = ic + 1;
            end else begin
                fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
                serve_burst($urandom_range(0, 3), 16'($urandom_range(0, 127)), 7, fa, la, seen, ok, lc);
                n_cmp++; if (seen !== la) begin n_bad++; $display("FAIL rand_bmem_addr[%0d] got %h want %h", it, seen, la); end
                wait_resp(6); tick();
                want_n = (fa >= 0) ? 0 : 1; want_c = lc + 2;
                mdl_valid = 1'b1; mdl_tag = la[31:5];
            end
            n_cmp++;
            if (resp_q.size() != want_n) begin
                n_bad++; $display("FAIL rand_count[%0d] got %0d want %0d", it, resp_q.size(), want_n);
            end else if (want_n == 1) begin
                n_cmp++; if (resp_q[0].c != want_c) begin n_bad++; $display("FAIL rand_latency[%0d] got cycle %0d want %0d", it, resp_q[0].c, want_c); end
                n_cmp++; if (resp_q[0].d !== mem_word(a)) begin n_bad++; $display("FAIL rand_rdata[%0d] got %h want %h", it, resp_q[0].d, mem_word(a)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit_stream(32'h6000_0000, "hit_stream");
        test_new_line();
        test_flush_fill();
        test_gapped();
        test_reset_mid_burst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
